// File: rtl/mult_sequencer.sv
// Operand-pair FIFO feeding a fixed-latency external multiplier; captures and holds each product.
// Optional accumulator of handshaken products is enabled by defining MULT_SEQ_ACCUM_EN.
module mult_sequencer #(
    parameter int unsigned MUL_LATENCY = 12,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_a,
    input  logic [3:0]  in_b,
    output logic        mul_start,
    output logic [3:0]  mul_in_1,
    output logic [3:0]  mul_in_2,
    input  logic [7:0]  mul_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
`ifdef MULT_SEQ_ACCUM_EN
    input  logic        acc_clr,
    output logic [11:0] acc_out,
`endif
    output logic        busy
);

    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_a_q, op_a_d;
    logic [3:0]         op_b_q, op_b_d;
    logic [7:0]         res_data_q, res_data_d;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        fill_q, fill_d;

    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic [7:0]         head;

    assign fifo_empty = (fill_q == '0);
    assign fifo_full  = (fill_q == (AW+1)'(FIFO_DEPTH));
    assign head       = mem_q[rd_ptr_q];

    assign push = in_valid && !fifo_full;
    // The head is popped on the IDLE->ISSUE edge so operands are already valid while mul_start is high.
    assign pop  = (state_q == IDLE) && !fifo_empty;

    // ---------------- FIFO ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + (AW+1)'(1);
            2'b01:   fill_d = fill_q - (AW+1)'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // ---------------- Sequencer FSM ----------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        res_data_d = res_data_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    op_a_d  = head[7:4];
                    op_b_d  = head[3:0];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(MUL_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    res_data_d = mul_out;
                    state_d    = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            res_data_q <= res_data_d;
        end
    end

    assign in_ready  = !fifo_full;
    assign mul_start = (state_q == ISSUE);
    assign mul_in_1  = op_a_q;
    assign mul_in_2  = op_b_q;
    assign res_valid = (state_q == HOLD);
    assign res_data  = res_data_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

`ifdef MULT_SEQ_ACCUM_EN
    // ---------------- Product accumulator ----------------
    logic [11:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if ((state_q == HOLD) && res_ready) begin
            acc_d = acc_q + {4'b0000, res_data_q};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_out = acc_q;
`endif

endmodule
